// File: rtl/seg_word_decoder.sv
// seg_word_decoder
//   Receive-side decoder for the 7-segment character stream. Each strobed
//   active-low pattern is mapped back to its 2-bit character code
//   (d=00, E=01, 1=10, blank=11). Three digits, HEX2 first, form a word.
//   The committed word is reported together with its rotation of "dE1"
//   and a flag for unrecognised patterns. Framing faults pulse sync_err.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high
//   seg_in[6:0]  in   active-low segments g..a, sampled when seg_valid=1
//   seg_valid    in   one-cycle digit strobe
//   frame_start  in   marks the HEX2 digit of a word (qualified by seg_valid)
//   word[5:0]    out  last committed word {HEX2,HEX1,HEX0}
//   word_valid   out  one-cycle pulse when word updates
//   shift[1:0]   out  rotation of word relative to d,E,1; 3 = not a rotation
//   bad_seg      out  last word contained an unrecognised pattern
//   sync_err     out  one-cycle pulse on a framing fault or timeout
module seg_word_decoder #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic       seg_valid,
  input  logic       frame_start,
  output logic [5:0] word,
  output logic       word_valid,
  output logic [1:0] shift,
  output logic       bad_seg,
  output logic       sync_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GOT1 = 2'd1;
  localparam logic [1:0] GOT2 = 2'd2;

  // The timer is compared before it increments, so the timeout fires on the
  // idle cycle that would bring it to TIMEOUT. A digit on that same cycle
  // wins because the seg_valid branch is checked first.
  localparam logic [9:0] TIMER_LAST = 10'(TIMEOUT - 1);

  localparam logic [1:0] CODE_D     = 2'b00;
  localparam logic [1:0] CODE_E     = 2'b01;
  localparam logic [1:0] CODE_ONE   = 2'b10;
  localparam logic [1:0] CODE_BLANK = 2'b11;

  logic [1:0] state;
  logic [9:0] timer;
  logic [1:0] hex2;
  logic [1:0] hex1;
  logic       bad_flag;

  logic [1:0] code;
  logic       code_bad;
  logic [5:0] next_word;
  logic [1:0] next_shift;

  always_comb begin
    code     = CODE_BLANK;
    code_bad = 1'b0;
    case (seg_in)
      7'b0100001: code = CODE_D;
      7'b0000110: code = CODE_E;
      7'b1001111: code = CODE_ONE;
      7'b1111111: code = CODE_BLANK;
      default:    code_bad = 1'b1;
    endcase
  end

  // Word as it would be committed if the current digit completes it.
  assign next_word = {hex2, hex1, code};

  always_comb begin
    case (next_word)
      {CODE_D,   CODE_E,   CODE_ONE}: next_shift = 2'd0;
      {CODE_E,   CODE_ONE, CODE_D}:   next_shift = 2'd1;
      {CODE_ONE, CODE_D,   CODE_E}:   next_shift = 2'd2;
      default:                        next_shift = 2'd3;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      hex2       <= CODE_BLANK;
      hex1       <= CODE_BLANK;
      bad_flag   <= 1'b0;
      word       <= 6'b111111;
      word_valid <= 1'b0;
      shift      <= 2'd3;
      bad_seg    <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      sync_err   <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (seg_valid) begin
            if (frame_start) begin
              hex2     <= code;
              bad_flag <= code_bad;
              state    <= GOT1;
            end else begin
              sync_err <= 1'b1;
            end
          end
        end
        GOT1, GOT2: begin
          if (seg_valid) begin
            timer <= '0;
            if (frame_start) begin
              // Resync: drop the partial word, this digit becomes HEX2.
              sync_err <= 1'b1;
              hex2     <= code;
              bad_flag <= code_bad;
              state    <= GOT1;
            end else if (state == GOT1) begin
              hex1     <= code;
              bad_flag <= bad_flag | code_bad;
              state    <= GOT2;
            end else begin
              word       <= next_word;
              shift      <= next_shift;
              bad_seg    <= bad_flag | code_bad;
              word_valid <= 1'b1;
              state      <= IDLE;
            end
          end else if (timer == TIMER_LAST) begin
            sync_err <= 1'b1;
            timer    <= '0;
            state    <= IDLE;
          end else begin
            timer <= timer + 10'd1;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_word_decoder.sv
module tb_seg_word_decoder;

  localparam int TIMEOUT = 4;

  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_B = 7'b1111111;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] seg_in;
  logic       seg_valid;
  logic       frame_start;
  logic [5:0] word;
  logic       word_valid;
  logic [1:0] shift;
  logic       bad_seg;
  logic       sync_err;

  seg_word_decoder #(.TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .seg_in      (seg_in),
    .seg_valid   (seg_valid),
    .frame_start (frame_start),
    .word        (word),
    .word_valid  (word_valid),
    .shift       (shift),
    .bad_seg     (bad_seg),
    .sync_err    (sync_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: pending digits of the current word and held outputs
  int q[$];
  bit q_bad;
  int idle;
  int exp_word, exp_shift, exp_bad, exp_wv, exp_se;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    q_bad = 0;
    idle = 0;
    exp_word = 63; exp_shift = 3; exp_bad = 0; exp_wv = 0; exp_se = 0;
  endtask

  task automatic decode(input logic [6:0] s, output int c, output bit b);
    logic [6:0] pats [4];
    pats[0] = SEG_D; pats[1] = SEG_E; pats[2] = SEG_1; pats[3] = SEG_B;
    c = 3; b = 1;
    for (int i = 0; i < 4; i++)
      if (s == pats[i]) begin c = i; b = 0; end
  endtask

  task automatic model_cycle(input logic v, input logic fs, input logic [6:0] s);
    int c;
    bit b;
    exp_wv = 0;
    exp_se = 0;
    if (v) begin
      decode(s, c, b);
      idle = 0;
      if (fs) begin
        if (q.size() > 0) exp_se = 1;
        q.delete();
        q.push_back(c);
        q_bad = b;
      end else if (q.size() == 0) begin
        exp_se = 1;
      end else begin
        q.push_back(c);
        q_bad = q_bad | b;
        if (q.size() == 3) begin
          exp_word  = q[0] * 16 + q[1] * 4 + q[2];
          exp_shift = 3;
          for (int r = 0; r < 3; r++)
            if (q[0] == r % 3 && q[1] == (r + 1) % 3 && q[2] == (r + 2) % 3)
              exp_shift = r;
          exp_bad = q_bad;
          exp_wv  = 1;
          q.delete();
        end
      end
    end else if (q.size() > 0) begin
      idle++;
      if (idle == TIMEOUT) begin
        exp_se = 1;
        q.delete();
        idle = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".word"},       int'(word),       exp_word);
    check({tag, ".shift"},      int'(shift),      exp_shift);
    check({tag, ".bad_seg"},    int'(bad_seg),    exp_bad);
    check({tag, ".word_valid"}, int'(word_valid), exp_wv);
    check({tag, ".sync_err"},   int'(sync_err),   exp_se);
  endtask

  task automatic step(input string tag, input logic v, input logic fs, input logic [6:0] s);
    seg_valid   = v;
    frame_start = fs;
    seg_in      = s;
    model_cycle(v, fs, s);
    @(posedge clock);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, SEG_B);
  endtask

  task automatic send_word(input string tag, input logic [6:0] a, input logic [6:0] b,
                           input logic [6:0] c);
    step(tag, 1'b1, 1'b1, a);
    step(tag, 1'b1, 1'b0, b);
    step(tag, 1'b1, 1'b0, c);
  endtask

  task automatic mid_cycle_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    #2 reset = 1'b0;
  endtask

  function automatic logic [6:0] rand_seg();
    int k = $urandom_range(0, 9);
    case (k)
      0, 1: return SEG_D;
      2, 3: return SEG_E;
      4, 5: return SEG_1;
      6:    return SEG_B;
      default: return 7'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    seg_in = SEG_B;
    seg_valid = 1'b0;
    frame_start = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_outputs("reset");
    #2 reset = 1'b0;

    // clean d,E,1
    send_word("dE1", SEG_D, SEG_E, SEG_1);
    check("dE1.word_const", int'(word), 6'b000110);
    check("dE1.shift_const", int'(shift), 0);
    step("dE1.after", 1'b0, 1'b0, SEG_B);
    check("dE1.pulse_one_cycle", int'(word_valid), 0);

    // back-to-back rotations
    send_word("E1d", SEG_E, SEG_1, SEG_D);
    check("E1d.word_const", int'(word), 6'b011000);
    send_word("1dE", SEG_1, SEG_D, SEG_E);
    check("1dE.shift_const", int'(shift), 2);
    idle_steps("gap", 2);

    // bad pattern, then clean word
    send_word("bad", SEG_D, 7'b0000000, SEG_1);
    check("bad.word_const", int'(word), 6'b001110);
    check("bad.flag_const", int'(bad_seg), 1);
    send_word("clean", SEG_D, SEG_E, SEG_1);
    check("clean.flag_const", int'(bad_seg), 0);

    // resync mid-word
    step("resync", 1'b1, 1'b1, SEG_D);
    step("resync", 1'b1, 1'b0, SEG_E);
    send_word("resync", SEG_B, SEG_E, SEG_1);
    check("resync.word_const", int'(word), 6'b110110);
    idle_steps("resync.gap", 1);

    // timeout: 4 idle cycles drop the word, then a stray digit
    step("tmo", 1'b1, 1'b1, SEG_D);
    idle_steps("tmo.idle", TIMEOUT);
    check("tmo.sync_const", int'(sync_err), 1);
    step("tmo.stray", 1'b1, 1'b0, SEG_E);
    check("tmo.stray_const", int'(sync_err), 1);
    // 3-cycle gap completes
    step("gap3", 1'b1, 1'b1, SEG_D);
    idle_steps("gap3.idle", TIMEOUT - 1);
    step("gap3", 1'b1, 1'b0, SEG_E);
    step("gap3", 1'b1, 1'b0, SEG_1);
    check("gap3.valid_const", int'(word_valid), 1);

    // reset while in GOT2
    step("rst_mid", 1'b1, 1'b1, SEG_E);
    step("rst_mid", 1'b1, 1'b0, SEG_1);
    mid_cycle_reset("rst_mid");
    check("rst_mid.word_const", int'(word), 6'b111111);
    send_word("post_rst", SEG_D, SEG_E, SEG_1);
    check("post_rst.shift_const", int'(shift), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic v, fs;
      int r = $urandom_range(0, 99);
      v  = (r < 70);
      fs = ($urandom_range(0, 99) < 25);
      if (i % 997 == 500) mid_cycle_reset("rand_rst");
      step("rand", v, fs, rand_seg());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_word_decoder.md
# seg_word_decoder

Receives a stream of 7-segment digit patterns, one per strobe, and recovers the 2-bit character codes (d, E, 1, blank) that drive our HEX displays. It assembles three digits into a word, ordered HEX2 first, and reports which rotation of "dE1" the word is. It also flags malformed patterns and framing faults. It sits on the receive side of the segment-pattern interface, inverting the character-to-segment encoding used for the display path.

## Interface
- TIMEOUT, default 255: maximum idle cycles allowed between digits of one word; range 1..1023.
- Clock  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
- Seg_in  in  7  active-low segment pattern [6:0] = g..a. Sampled only when Seg_valid=1.
- Seg_valid  in  1  one-cycle strobe; Seg_in carries one digit.
- Frame_start  in  1  qualifies Seg_valid. 1 marks the first digit (HEX2) of a word.
- Word  out  6  last complete word: [5:4]=HEX2, [3:2]=HEX1, [1:0]=HEX0 codes.
- Word_valid  out  1  one-cycle pulse when Word updates.
- Shift  out  2  rotation of last word relative to d,E,1. 3 means not a rotation.
- Bad_seg  out  1  1 if the last word contained an unrecognised pattern. Valid with Word.
- Sync_err  out  1  one-cycle pulse on any framing fault.

## Operation
- Pattern decode (combinational on Seg_in):
  - 0100001 -> 00 (d)
  - 0000110 -> 01 (E)
  - 1001111 -> 10 (1)
  - 1111111 -> 11 (blank)
  - Any other pattern -> 11 and sets the per-word bad flag.
- FSM states: IDLE, GOT1, GOT2.
- IDLE:
  - Seg_valid & Frame_start: store digit in HEX2 slot, clear bad flag, clear timer -> GOT1.
  - Seg_valid & !Frame_start: digit discarded, Sync_err pulse, stay IDLE.
- GOT1:
  - Seg_valid & !Frame_start: store HEX1 -> GOT2.
- GOT2:
  - Seg_valid & !Frame_start: store HEX0, commit word -> IDLE.
- Frame_start in GOT1/GOT2 with Seg_valid: the partial word is dropped and Sync_err pulses. The current digit restarts as HEX2 with the bad flag reinitialised from that digit -> GOT1.
- Timer, 10 bits: clears on every accepted digit and increments each cycle in GOT1/GOT2 without Seg_valid. When it reaches TIMEOUT, the partial word is dropped, Sync_err pulses and the FSM goes -> IDLE. A digit arriving on the same cycle the timer hits TIMEOUT is accepted; the timeout does not fire.
- Frame_start without Seg_valid is ignored in every state.
- Commit updates Word, Bad_seg and Shift together and pulses Word_valid. These outputs hold until the next commit.
- Shift:
  - {00,01,10} -> 0
  - {01,10,00} -> 1
  - {10,00,01} -> 2
  - anything else, including blanks or bad digits -> 3

## Timing
- Reset values:
  - Word = 6'b111111
  - Word_valid = 0
  - Shift = 3
  - Bad_seg = 0
  - Sync_err = 0
  - FSM = IDLE, timer = 0
- All outputs are registered.
- Word, Shift, Bad_seg and Word_valid appear 1 cycle after the third digit's Seg_valid.
- Sync_err appears 1 cycle after the causing event.
- Back-to-back words are supported: Seg_valid may be high every cycle. A word's commit cycle may coincide with the next word's Frame_start digit and both are handled.
- Reset mid-word discards the partial word with no Word_valid and no Sync_err.

## Test plan
- Reset, then send 0100001, 0000110, 1001111 (FS on first) on consecutive cycles -> one cycle later: Word = 000110, Shift = 0, Bad_seg = 0, Word_valid pulse for exactly 1 cycle.
- Send words E,1,d then 1,d,E back-to-back with no gap -> two consecutive Word_valid pulses; Shift = 1 then 2; Word = 011000 then 100001.
- Send d, 0000000, 1 -> Word = 001110, Shift = 3, Bad_seg = 1. Follow with a clean d,E,1 -> Bad_seg returns to 0.
- Send d, E, then FS+1111111, E, 1 -> Sync_err pulses once at the second FS; then Word = 110110 with Shift = 3 and no Word_valid for the aborted word.
- TIMEOUT=4: send d, wait 4 idle cycles -> Sync_err pulse, FSM IDLE. A following non-FS digit gives a second Sync_err and no Word_valid. Repeat with a 3-cycle gap -> word completes normally.
- Assert Reset while in GOT2 -> all outputs at reset values asynchronously; the next full d,E,1 word decodes with Shift = 0.
